mnist_result_tx: RTL and testbench
==================================

# mnist_result_tx

Output-side transmitter for the MNIST accelerator: it takes one completed set of class scores from the classifier core and streams it off-chip as a byte frame over the 8-bit dedicated output pins. Each byte uses a 4-phase valid/ack handshake. It computes the predicted digit (argmax) on the fly while the scores are sent. It is the return path that pairs with the pixel-input side of the chip top level.

## Interface
- `HEADER`, default `8'hA5`: first byte of every frame.
- `NUM_CLASSES`, default `10`: number of scores per frame; legal range 2..16.
- `clk` in 1: the single clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `ena` in 1: when low, all state and outputs hold; when high, normal operation.
- `start` in 1: request to send; sampled only in IDLE.
- `scores` in `8*NUM_CLASSES`: unsigned scores; bits `[8*i+7:8*i]` hold digit i.
- `tx_ack` in 1: off-chip acknowledge, asynchronous to `clk`.
- `tx_data` out 8: frame byte; drives `uo_out`.
- `tx_valid` out 1: byte-valid strobe; drives a `uio_out` bit with its `uio_oe` bit set.
- `busy` out 1: high from start acceptance until the frame completes.
- `done` out 1: one-cycle pulse when the final byte's handshake completes.

## Operation
- Frame order: `HEADER`, score[0]..score[NUM_CLASSES-1], argmax byte, then an optional checksum byte (see Configuration).
- Argmax byte: index of the largest score, zero-extended to 8 bits.
  - A score replaces the running maximum only if it is strictly greater, so ties resolve to the lowest index.
  - The running maximum is updated as each score byte's handshake completes.
- `tx_ack` passes through a 2-flop synchronizer to produce `ack_s`; only `ack_s` is used internally.
- States:
  - **IDLE**: `busy`=0 and `tx_valid`=0. If `start`=1, latch `scores`, clear the byte index, max value and checksum, then go to SEND with `tx_valid`<=1 and `tx_data`<=`HEADER`.
  - **SEND**: `tx_valid`=1 and `tx_data` stable. If `ack_s`=1, set `tx_valid`<=0 and go to RELEASE.
  - **RELEASE**: wait for `ack_s`=0. Then update argmax/checksum with the byte just sent and advance the index.
    - If bytes remain: load the next byte, set `tx_valid`<=1, go to SEND.
    - Otherwise: go to IDLE with `done`<=1 and `busy`<=0.
- `start` while not in IDLE is ignored. Changes on `scores` after latching have no effect on the current frame.
- `tx_data` changes only while `tx_valid`=0, or on the same edge that raises `tx_valid`.
- If `ack_s` is already 1 when a new byte is presented, the handshake still completes: SEND exits on the next edge. The off-chip side must not do this; behaviour is defined but not relied on.
- `rst_n`=0 at any point, including mid-frame, aborts the frame. On the next edge: IDLE, all outputs 0, synchronizer cleared.
- `ena`=0 freezes state, outputs and synchronizer; the frame resumes unchanged when `ena` returns to 1.

## Timing
- Reset values: `tx_data`=0x00, `tx_valid`=0, `busy`=0, `done`=0.
- All outputs are registered.
- `start` sampled at edge k: `busy`=1, `tx_valid`=1 and `tx_data`=`HEADER` are visible after edge k.
- `tx_ack` rising before edge m: `ack_s`=1 after edge m+1; `tx_valid` falls after edge m+2.
- `tx_ack` falling before edge n: next byte and `tx_valid`=1 appear after edge n+2.
- Minimum cycles per byte: 6, with `tx_ack` following `tx_valid` combinationally.
- Full frame with the checksum byte, NUM_CLASSES=10: 13 bytes.
- `done` is high for exactly one cycle. `busy` falls on the same edge that `done` rises.
- A `start` at the edge after `done` is accepted.

## Configuration
- `MNIST_RESULT_TX_CHECKSUM_EN` defined: a checksum byte is appended after the argmax byte.
  - Checksum = XOR of all score bytes and the argmax byte; `HEADER` is excluded.
- Not defined: the frame ends after the argmax byte (12 bytes at NUM_CLASSES=10). The checksum register and logic are absent.

## Test plan
- Reset mid-frame: assert `rst_n`=0 for one cycle during byte 4 -> next cycle all outputs 0 and state IDLE; a fresh `start` yields byte 0 = 0xA5.
- Single winner: all scores 0x00 except score[7]=0xC8 -> frame A5,00×7,C8,00,00,07; with the macro, a final byte 0xCF; `done` pulses once.
- Tie: score[2]=score[5]=0x40, others 0x00 -> argmax byte 0x02; checksum 0x02.
- Ack timing: the bench delays `tx_ack` by 0..20 random cycles per phase -> no byte is dropped or duplicated; `tx_data` never changes while `tx_valid`=1; `tx_valid` falls exactly 2 edges after `tx_ack` rises.
- `start` while busy, and `scores` changed mid-frame -> the frame is unaffected and no second frame is sent.
- `ena`=0 for 10 cycles mid-SEND -> outputs frozen; the frame completes correctly after `ena` returns to 1.

Source files
------------

// File: rtl/mnist_result_tx.sv
// rtl/mnist_result_tx.sv - MNIST class-score frame transmitter over a 4-phase valid/ack byte link
// Optional trailing XOR checksum byte when MNIST_RESULT_TX_CHECKSUM_EN is defined.
module mnist_result_tx #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         NUM_CLASSES = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     start,
  input  logic [8*NUM_CLASSES-1:0] scores,
  input  logic                     tx_ack,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int IW = 5;
`ifdef MNIST_RESULT_TX_CHECKSUM_EN
  localparam int LAST_IDX = NUM_CLASSES + 2;
`else
  localparam int LAST_IDX = NUM_CLASSES + 1;
`endif
  localparam logic [IW-1:0] LAST = IW'(LAST_IDX);
  localparam logic [IW-1:0] NC   = IW'(NUM_CLASSES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_RELEASE
  } state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [8*NUM_CLASSES-1:0] scores_q, scores_d;
  logic [7:0]               max_val_q, max_val_d;
  logic [3:0]               max_idx_q, max_idx_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic                     tx_valid_q, tx_valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     ack_meta_q, ack_s_q;
`ifdef MNIST_RESULT_TX_CHECKSUM_EN
  logic [7:0]               csum_q, csum_d, new_csum;
`endif

  logic [IW-1:0] sidx;
  logic [7:0]    sent_score, new_max_val;
  logic [3:0]    new_max_idx;
  logic          is_score;

  function automatic logic [7:0] get_score(input logic [8*NUM_CLASSES-1:0] v,
                                           input logic [IW-1:0] k);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (k == IW'(i)) r = v[8*i +: 8];
    end
    return r;
  endfunction

  // tx_ack is asynchronous; only the second flop is ever looked at.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else if (ena) begin
      ack_meta_q <= tx_ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  // idx_q is the byte on the wire: 0 header, 1..NC scores, NC+1 argmax, NC+2 checksum.
  always_comb begin
    sidx        = idx_q - 5'd1;
    is_score    = (idx_q >= 5'd1) && (idx_q <= NC);
    sent_score  = get_score(scores_q, sidx);
    new_max_val = max_val_q;
    new_max_idx = max_idx_q;
    if (is_score && (sent_score > max_val_q)) begin
      new_max_val = sent_score;
      new_max_idx = sidx[3:0];
    end
  end

`ifdef MNIST_RESULT_TX_CHECKSUM_EN
  always_comb begin
    new_csum = csum_q;
    if ((idx_q >= 5'd1) && (idx_q <= NC + 5'd1)) new_csum = csum_q ^ tx_data_q;
  end
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    scores_d   = scores_q;
    max_val_d  = max_val_q;
    max_idx_d  = max_idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef MNIST_RESULT_TX_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          scores_d   = scores;
          idx_d      = '0;
          max_val_d  = 8'h00;
          max_idx_d  = 4'h0;
`ifdef MNIST_RESULT_TX_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
          tx_data_d  = HEADER;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (ack_s_q) begin
          tx_valid_d = 1'b0;
          state_d    = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!ack_s_q) begin
          max_val_d = new_max_val;
          max_idx_d = new_max_idx;
`ifdef MNIST_RESULT_TX_CHECKSUM_EN
          csum_d    = new_csum;
`endif
          if (idx_q == LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d      = idx_q + 5'd1;
            tx_valid_d = 1'b1;
            state_d    = S_SEND;
            if (idx_q < NC) begin
              tx_data_d = get_score(scores_q, idx_q);
            end else if (idx_q == NC) begin
              tx_data_d = {4'h0, new_max_idx};
            end else begin
`ifdef MNIST_RESULT_TX_CHECKSUM_EN
              tx_data_d = new_csum;
`else
              tx_data_d = tx_data_q;
`endif
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      scores_q   <= '0;
      max_val_q  <= 8'h00;
      max_idx_q  <= 4'h0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MNIST_RESULT_TX_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else if (ena) begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      scores_q   <= scores_d;
      max_val_q  <= max_val_d;
      max_idx_q  <= max_idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef MNIST_RESULT_TX_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mnist_result_tx.sv
// tb/tb_mnist_result_tx.sv - scoreboard bench for mnist_result_tx acting as the off-chip receiver
module tb_mnist_result_tx;
  localparam int NC = 10;
`ifdef MNIST_RESULT_TX_CHECKSUM_EN
  localparam int NB = NC + 3;
`else
  localparam int NB = NC + 2;
`endif

  logic            clk = 1'b0;
  logic            rst_n, ena, start, tx_ack;
  logic [8*NC-1:0] scores;
  logic [7:0]      tx_data;
  logic            tx_valid, busy, done;

  int pass_cnt = 0, total_cnt = 0;
  int tmo_cnt, unstable, fall_bad, frozen_bad, busy_bad, done_cnt;
  bit chain_ok;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  mnist_result_tx #(.HEADER(8'hA5), .NUM_CLASSES(NC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .scores(scores),
    .tx_ack(tx_ack), .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (done && busy) busy_bad++;
  end

  task automatic push_expected(input logic [8*NC-1:0] sc);
    logic [7:0] mx, cs, s;
    int am;
    mx = 0; am = 0; cs = 0;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < NC; i++) begin
      s = sc[8*i +: 8];
      exp_q.push_back(s);
      cs = cs ^ s;
      if (s > mx) begin mx = s; am = i; end
    end
    exp_q.push_back(8'(am));
`ifdef MNIST_RESULT_TX_CHECKSUM_EN
    exp_q.push_back(cs ^ 8'(am));
`endif
  endtask

  task automatic clear_flags();
    tmo_cnt = 0; unstable = 0; fall_bad = 0; frozen_bad = 0; busy_bad = 0; done_cnt = 0;
  endtask

  task automatic drive_frame(input logic [8*NC-1:0] sc, input int dmax, input int freeze_at,
                             input bit disturb, input int abort_at, input bit do_start, input bit chain);
    int t, cnt, dly;
    logic [7:0] d;
    if (do_start) begin
      @(negedge clk); scores = sc; start = 1;
      @(negedge clk); start = 0;
    end
    for (int b = 0; b < NB; b++) begin
      t = 0;
      while (!tx_valid && t < 300) begin @(negedge clk); t++; end
      if (!tx_valid) begin tmo_cnt++; return; end
      d = tx_data;
      got_q.push_back(d);
      if (b == abort_at) begin
        rst_n = 0; @(negedge clk); rst_n = 1;
        return;
      end
      if (disturb && b == 2) begin start = 1; scores = ~sc; end
      if (disturb && b == 6) start = 0;
      if (b == freeze_at) begin
        ena = 0; tx_ack = 1;
        repeat (10) begin
          @(negedge clk);
          if (tx_valid !== 1'b1 || tx_data !== d || busy !== 1'b1) frozen_bad++;
        end
        ena = 1;
      end else begin
        dly = $urandom_range(dmax, 0);
        repeat (dly) begin
          @(negedge clk);
          if (tx_valid !== 1'b1 || tx_data !== d) unstable++;
        end
        tx_ack = 1;
      end
      cnt = 0;
      do begin
        @(negedge clk); cnt++;
        if (tx_valid && tx_data !== d) unstable++;
      end while (tx_valid && cnt < 50);
      if (cnt != 3) fall_bad++;
      dly = $urandom_range(dmax, 0);
      repeat (dly) begin @(negedge clk); if (tx_valid) fall_bad++; end
      if (chain && b == NB - 1) start = 1;
      tx_ack = 0;
    end
    if (chain) begin
      t = 0;
      while (!done && t < 20) begin @(negedge clk); t++; end
      if (!done) tmo_cnt++;
      else begin
        @(negedge clk);
        chain_ok = busy && tx_valid && (tx_data == 8'hA5);
      end
      start = 0;
    end else begin
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; ena = 1; start = 0; tx_ack = 0; scores = '0;
    repeat (3) @(negedge clk);
    total_cnt++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h exp 00", tx_data); else pass_cnt++;
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b exp 0", tx_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single_winner();
    logic [8*NC-1:0] sc;
    logic [7:0] e, g;
    int i;
    sc = '0; sc[8*7 +: 8] = 8'hC8;
    clear_flags(); exp_q.delete(); got_q.delete();
    push_expected(sc);
    drive_frame(sc, 0, -1, 0, -1, 1, 0);
    total_cnt++; if (got_q.size() != NB) $display("FAIL winner_len got %0d exp %0d", got_q.size(), NB); else pass_cnt++;
    i = 0;
    while (exp_q.size() && got_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total_cnt++; if (g !== e) $display("FAIL winner_byte%0d got %h exp %h", i, g, e); else pass_cnt++;
      i++;
    end
    total_cnt++; if (done_cnt != 1) $display("FAIL winner_done got %0d pulses exp 1", done_cnt); else pass_cnt++;
    total_cnt++;
    if (tmo_cnt + unstable + fall_bad + busy_bad != 0)
      $display("FAIL winner_timing got tmo=%0d unstable=%0d fall=%0d busy=%0d exp all 0", tmo_cnt, unstable, fall_bad, busy_bad);
    else pass_cnt++;
  endtask

  task automatic test_tie();
    logic [8*NC-1:0] sc;
    logic [7:0] e, g;
    int i;
    sc = '0; sc[8*2 +: 8] = 8'h40; sc[8*5 +: 8] = 8'h40;
    clear_flags(); exp_q.delete(); got_q.delete();
    push_expected(sc);
    drive_frame(sc, 2, -1, 0, -1, 1, 0);
    total_cnt++; if (got_q.size() != NB) $display("FAIL tie_len got %0d exp %0d", got_q.size(), NB); else pass_cnt++;
    i = 0;
    while (exp_q.size() && got_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total_cnt++; if (g !== e) $display("FAIL tie_byte%0d got %h exp %h", i, g, e); else pass_cnt++;
      i++;
    end
    total_cnt++; if (done_cnt != 1 || fall_bad != 0) $display("FAIL tie_done got done=%0d fall=%0d exp 1/0", done_cnt, fall_bad); else pass_cnt++;
  endtask

  task automatic test_random_ack();
    logic [8*NC-1:0] sc;
    logic [7:0] e, g;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < NC; k++) sc[8*k +: 8] = 8'($urandom_range(255, 0));
      clear_flags(); exp_q.delete(); got_q.delete();
      push_expected(sc);
      drive_frame(sc, 20, -1, 0, -1, 1, 0);
      total_cnt++; if (got_q.size() != NB) $display("FAIL rand%0d_len got %0d exp %0d", f, got_q.size(), NB); else pass_cnt++;
      while (exp_q.size() && got_q.size()) begin
        e = exp_q.pop_front(); g = got_q.pop_front();
        total_cnt++; if (g !== e) $display("FAIL rand%0d_byte got %h exp %h", f, g, e); else pass_cnt++;
      end
      total_cnt++;
      if (tmo_cnt + unstable + fall_bad + busy_bad != 0 || done_cnt != 1)
        $display("FAIL rand%0d_timing got tmo=%0d unstable=%0d fall=%0d busy=%0d done=%0d exp 0/0/0/0/1",
                 f, tmo_cnt, unstable, fall_bad, busy_bad, done_cnt);
      else pass_cnt++;
    end
  endtask

  task automatic test_disturb();
    logic [8*NC-1:0] sc;
    logic [7:0] e, g;
    int extra;
    for (int k = 0; k < NC; k++) sc[8*k +: 8] = 8'(k * 17 + 3);
    clear_flags(); exp_q.delete(); got_q.delete();
    push_expected(sc);
    drive_frame(sc, 3, -1, 1, -1, 1, 0);
    extra = 0;
    repeat (20) begin @(negedge clk); if (tx_valid || busy) extra++; end
    total_cnt++; if (got_q.size() != NB) $display("FAIL disturb_len got %0d exp %0d", got_q.size(), NB); else pass_cnt++;
    while (exp_q.size() && got_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total_cnt++; if (g !== e) $display("FAIL disturb_byte got %h exp %h", g, e); else pass_cnt++;
    end
    total_cnt++; if (extra != 0 || done_cnt != 1) $display("FAIL disturb_second_frame got active=%0d done=%0d exp 0/1", extra, done_cnt); else pass_cnt++;
  endtask

  task automatic test_ena_freeze();
    logic [8*NC-1:0] sc;
    logic [7:0] e, g;
    for (int k = 0; k < NC; k++) sc[8*k +: 8] = 8'(200 - k * 9);
    clear_flags(); exp_q.delete(); got_q.delete();
    push_expected(sc);
    drive_frame(sc, 1, 3, 0, -1, 1, 0);
    total_cnt++; if (frozen_bad != 0) $display("FAIL freeze_hold got %0d changed cycles exp 0", frozen_bad); else pass_cnt++;
    total_cnt++; if (got_q.size() != NB) $display("FAIL freeze_len got %0d exp %0d", got_q.size(), NB); else pass_cnt++;
    while (exp_q.size() && got_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total_cnt++; if (g !== e) $display("FAIL freeze_byte got %h exp %h", g, e); else pass_cnt++;
    end
    total_cnt++; if (fall_bad != 0 || done_cnt != 1) $display("FAIL freeze_timing got fall=%0d done=%0d exp 0/1", fall_bad, done_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [8*NC-1:0] sc;
    logic [7:0] e, g;
    for (int k = 0; k < NC; k++) sc[8*k +: 8] = 8'(k + 1);
    clear_flags(); exp_q.delete(); got_q.delete();
    push_expected(sc);
    drive_frame(sc, 1, -1, 0, 4, 1, 0);
    total_cnt++;
    if (tx_data !== 8'h00 || tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_outputs got data=%h valid=%b busy=%b done=%b exp 00/0/0/0", tx_data, tx_valid, busy, done);
    else pass_cnt++;
    total_cnt++; if (got_q.size() != 5) $display("FAIL abort_len got %0d exp 5", got_q.size()); else pass_cnt++;
    while (got_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total_cnt++; if (g !== e) $display("FAIL abort_byte got %h exp %h", g, e); else pass_cnt++;
    end
    repeat (5) @(negedge clk);
    total_cnt++; if (tx_valid !== 1'b0 || done_cnt != 0) $display("FAIL abort_idle got valid=%b done=%0d exp 0/0", tx_valid, done_cnt); else pass_cnt++;
    clear_flags(); exp_q.delete(); got_q.delete();
    push_expected(sc);
    drive_frame(sc, 1, -1, 0, -1, 1, 0);
    total_cnt++; if (got_q.size() != NB) $display("FAIL restart_len got %0d exp %0d", got_q.size(), NB); else pass_cnt++;
    while (exp_q.size() && got_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total_cnt++; if (g !== e) $display("FAIL restart_byte got %h exp %h", g, e); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [8*NC-1:0] sc;
    logic [7:0] e, g;
    for (int k = 0; k < NC; k++) sc[8*k +: 8] = 8'(k * 29);
    clear_flags(); exp_q.delete(); got_q.delete(); chain_ok = 0;
    push_expected(sc);
    push_expected(sc);
    drive_frame(sc, 0, -1, 0, -1, 1, 1);
    total_cnt++; if (!chain_ok) $display("FAIL b2b_accept got busy=%b valid=%b data=%h exp 1/1/a5", busy, tx_valid, tx_data); else pass_cnt++;
    drive_frame(sc, 0, -1, 0, -1, 0, 0);
    total_cnt++; if (got_q.size() != 2 * NB) $display("FAIL b2b_len got %0d exp %0d", got_q.size(), 2 * NB); else pass_cnt++;
    while (exp_q.size() && got_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total_cnt++; if (g !== e) $display("FAIL b2b_byte got %h exp %h", g, e); else pass_cnt++;
    end
    total_cnt++;
    if (done_cnt != 2 || busy_bad != 0 || fall_bad != 0)
      $display("FAIL b2b_done got done=%0d busy_overlap=%0d fall=%0d exp 2/0/0", done_cnt, busy_bad, fall_bad);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_winner();
    test_tie();
    test_random_ack();
    test_disturb();
    test_ena_freeze();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
